// File: rtl/bubble_sort_pkg.sv
// Shared types and helpers for the sequential bubble sorter.
//   state_e   : controller state (LOAD -> SORT -> DRAIN -> LOAD)
//   max_swaps : worst-case swap count for an n-word batch
//   cnt_width : width needed to hold 0..max_swaps(n), never below 1 bit
package bubble_sort_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  function automatic int max_swaps(input int n);
    return n * (n - 1) / 2;
  endfunction

  // A single-word batch never swaps; keep the counter at least one bit wide.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(max_swaps(n) + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/bubble_cmp_swap.sv
// Combinational compare-swap element, the one datapath unit shared by every
// compare step of the sorter.
//   a, b : pair of unsigned words, a at the lower buffer index
//   lo   : smaller word (a when equal)
//   hi   : larger word (b when equal)
//   swap : b strictly less than a; equal words stay put so the sort is stable
module bubble_cmp_swap #(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] hi,
  output logic              swap
);

  always_comb begin
    swap = (b < a);
    lo   = swap ? b : a;
    hi   = swap ? a : b;
  end

endmodule

// File: rtl/bubble_sort_seq.sv
// Sequential bubble sorter: collects DATA_N words, sorts them ascending with
// one compare-swap per clock (early exit after a swap-free pass), then streams
// them out smallest first.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_data     : input word stream; in_ready high only in LOAD
//   out_valid/out_ready  : output handshake; out_valid high only in DRAIN
//   out_data/out_last    : sorted word, out_last marks the final word
//   busy                 : high in SORT and DRAIN
//   swap_cnt             : swaps of current/last batch, cleared on the next
//                          batch's first input handshake
module bubble_sort_seq
  import bubble_sort_pkg::*;
#(
  parameter int DATA_N = 4,
  parameter int DATA_W = 4,
  parameter int CNT_W  = cnt_width(DATA_N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic [CNT_W-1:0]  swap_cnt
);

  localparam int IDX_W = (DATA_N > 1) ? $clog2(DATA_N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_N - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] mem_q [DATA_N];
  logic [DATA_W-1:0] mem_d [DATA_N];
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
  logic [IDX_W-1:0]  i_q, i_d;
  logic [IDX_W-1:0]  j_q, j_d;
  logic              swapped_q, swapped_d;
  logic [CNT_W-1:0]  swap_cnt_q, swap_cnt_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              busy_q, busy_d;

  logic [IDX_W-1:0]  i_b;
  logic [DATA_W-1:0] cmp_lo, cmp_hi;
  logic              cmp_swap;
  logic              pass_swapped;

  // Upper compare index, clamped so a one-word buffer is never read out of range.
  assign i_b = (i_q == LAST_IDX) ? i_q : i_q + IDX_W'(1);

  bubble_cmp_swap #(
    .DATA_W(DATA_W)
  ) u_cmp (
    .a   (mem_q[i_q]),
    .b   (mem_q[i_b]),
    .lo  (cmp_lo),
    .hi  (cmp_hi),
    .swap(cmp_swap)
  );

  always_comb begin
    state_d      = state_q;
    mem_d        = mem_q;
    wr_idx_d     = wr_idx_q;
    rd_idx_d     = rd_idx_q;
    i_d          = i_q;
    j_d          = j_q;
    swapped_d    = swapped_q;
    swap_cnt_d   = swap_cnt_q;
    pass_swapped = swapped_q | cmp_swap;

    unique case (state_q)
      LOAD: begin
        if (in_valid && in_ready_q) begin
          mem_d[wr_idx_q] = in_data;
          if (wr_idx_q == '0) swap_cnt_d = '0;
          if (wr_idx_q == LAST_IDX) begin
            // wr_idx returns to 0 here rather than on the drain handshake;
            // it is unused outside LOAD, so the behaviour is identical.
            wr_idx_d  = '0;
            i_d       = '0;
            j_d       = '0;
            swapped_d = 1'b0;
            state_d   = (DATA_N == 1) ? DRAIN : SORT;
          end else begin
            wr_idx_d = wr_idx_q + IDX_W'(1);
          end
        end
      end
      SORT: begin
        if (cmp_swap) begin
          mem_d[i_q] = cmp_lo;
          mem_d[i_b] = cmp_hi;
          swapped_d  = 1'b1;
          swap_cnt_d = swap_cnt_q + CNT_W'(1);
        end
        if (int'(i_q) < DATA_N - 2 - int'(j_q)) begin
          i_d = i_q + IDX_W'(1);
        end else if (!pass_swapped || (int'(j_q) == DATA_N - 2)) begin
          state_d = DRAIN;
        end else begin
          j_d       = j_q + IDX_W'(1);
          i_d       = '0;
          swapped_d = 1'b0;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (rd_idx_q == LAST_IDX) begin
            rd_idx_d = '0;
            wr_idx_d = '0;
            state_d  = LOAD;
          end else begin
            rd_idx_d = rd_idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = LOAD;
    endcase

    // Status outputs are registered from the next-state values so they line
    // up with the state they describe without a cycle of lag.
    in_ready_d  = (state_d == LOAD);
    out_valid_d = (state_d == DRAIN);
    busy_d      = (state_d != LOAD);
    out_last_d  = (state_d == DRAIN) && (rd_idx_d == LAST_IDX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      for (int unsigned k = 0; k < DATA_N; k++) mem_q[k] <= '0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      i_q         <= '0;
      j_q         <= '0;
      swapped_q   <= 1'b0;
      swap_cnt_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      i_q         <= i_d;
      j_q         <= j_d;
      swapped_q   <= swapped_d;
      swap_cnt_q  <= swap_cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign swap_cnt  = swap_cnt_q;
  assign out_data  = mem_q[rd_idx_q];

endmodule

// File: tb/tb_bubble_sort_seq.sv
// Bench for bubble_sort_seq: a 4-word instance driven from a directed table,
// a mid-sort reset sequence and random batches, plus a 1-word instance.
module tb_bubble_sort_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       iv4, ir4, or4, ov4, ol4, busy4;
  logic [3:0] id4, od4;
  logic [2:0] sc4;

  logic       iv1, ir1, or1, ov1, ol1, busy1;
  logic [3:0] id1, od1;
  logic [0:0] sc1;

  int checks   = 0;
  int failures = 0;

  bubble_sort_seq #(.DATA_N(4), .DATA_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_data(id4), .in_ready(ir4),
    .out_valid(ov4), .out_ready(or4), .out_data(od4), .out_last(ol4),
    .busy(busy4), .swap_cnt(sc4)
  );

  bubble_sort_seq #(.DATA_N(1), .DATA_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_data(id1), .in_ready(ir1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_last(ol1),
    .busy(busy1), .swap_cnt(sc1)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, want);
    end
  endtask

  function automatic logic [15:0] pack4(input int a, input int b, input int c, input int d);
    logic [15:0] v;
    v = {d[3:0], c[3:0], b[3:0], a[3:0]};
    return v;
  endfunction

  // Reference: bubble passes over a plain array, pass p compares 3-p pairs,
  // stopping after the first pass with no swap. trace[n] = swaps after n compares.
  task automatic model4(input logic [15:0] vin, output logic [15:0] sorted,
                        output int cyc, output int swp, output int trace[16]);
    int a[4];
    int t;
    bit any;
    for (int k = 0; k < 4; k++) a[k] = int'(vin[4*k +: 4]);
    for (int k = 0; k < 16; k++) trace[k] = 0;
    cyc = 0;
    swp = 0;
    for (int p = 0; p < 3; p++) begin
      any = 1'b0;
      for (int i = 0; i < 3 - p; i++) begin
        if (a[i+1] < a[i]) begin
          t = a[i]; a[i] = a[i+1]; a[i+1] = t;
          swp++;
          any = 1'b1;
        end
        cyc++;
        trace[cyc] = swp;
      end
      if (!any) break;
    end
    for (int k = 0; k < 4; k++) sorted[4*k +: 4] = a[k][3:0];
  endtask

  task automatic run4(input logic [15:0] vin, input logic [15:0] want_out,
                      input int want_cyc, input int want_swp, input logic [31:0] pat,
                      input bit noise, input bit bubbles, input string tag);
    logic [15:0] m_sorted;
    int m_cyc, m_swp;
    int trace[16];
    int k, n, idx, cyc;
    model4(vin, m_sorted, m_cyc, m_swp, trace);

    k = 0; n = 0;
    while (k < 4 && n < 64) begin
      check({tag, " load in_ready"}, ir4, 1);
      iv4 = bubbles ? ($urandom_range(0, 3) != 0) : 1'b1;
      id4 = vin[4*k +: 4];
      @(posedge clk);
      if (iv4) k++;
      @(negedge clk);
      n++;
      if (iv4 && k == 1) check({tag, " swap_cnt cleared"}, sc4, 0);
    end
    check({tag, " words loaded"}, k, 4);
    iv4 = noise;
    id4 = 4'($urandom);

    n = 0;
    while (!ov4 && n < 40) begin
      check({tag, " sort busy"}, busy4, 1);
      check({tag, " sort in_ready"}, ir4, 0);
      if (n < 16) check($sformatf("%s swap_cnt step %0d", tag, n), sc4, trace[n]);
      @(posedge clk);
      @(negedge clk);
      n++;
      if (noise) id4 = 4'($urandom);
    end
    check({tag, " sort cycles"}, n, want_cyc);
    check({tag, " swap_cnt"}, sc4, want_swp);

    idx = 0; cyc = 0;
    while (idx < 4 && cyc < 64) begin
      or4 = (cyc < 32) ? pat[cyc] : 1'b1;
      check({tag, " out_valid"}, ov4, 1);
      check($sformatf("%s out_data[%0d]", tag, idx), od4, want_out[4*idx +: 4]);
      check($sformatf("%s out_last[%0d]", tag, idx), ol4, (idx == 3) ? 1 : 0);
      check({tag, " drain in_ready"}, ir4, 0);
      check({tag, " drain busy"}, busy4, 1);
      @(posedge clk);
      if (or4) idx++;
      @(negedge clk);
      cyc++;
    end
    check({tag, " words drained"}, idx, 4);
    iv4 = 1'b0;
    or4 = 1'($urandom);
    check({tag, " in_ready after drain"}, ir4, 1);
    check({tag, " out_valid after drain"}, ov4, 0);
    check({tag, " busy after drain"}, busy4, 0);
    check({tag, " out_last after drain"}, ol4, 0);
    check({tag, " swap_cnt held"}, sc4, want_swp);
  endtask

  typedef struct {
    logic [15:0] vin;
    logic [15:0] want;
    int          cyc;
    int          swp;
    logic [31:0] pat;
  } vec_t;

  vec_t tbl[4];

  initial begin
    logic [15:0] m_sorted, vin;
    int m_cyc, m_swp;
    int trace[16];

    tbl[0] = '{pack4(3,1,2,0), pack4(0,1,2,3), 6, 5, 32'hFFFF_FFFF};
    tbl[1] = '{pack4(0,1,2,3), pack4(0,1,2,3), 3, 0, 32'hFFFF_FFFF};
    tbl[2] = '{pack4(2,2,1,1), pack4(1,1,2,2), 6, 4, 32'hFFFF_FFFF};
    tbl[3] = '{pack4(3,2,1,0), pack4(0,1,2,3), 6, 6, 32'hFFFF_FFE9};

    rst_n = 1'b0;
    iv4 = 1'b0; id4 = '0; or4 = 1'b1;
    iv1 = 1'b0; id1 = '0; or1 = 1'b1;
    repeat (3) @(negedge clk);
    check("reset in_ready", ir4, 1);
    check("reset out_valid", ov4, 0);
    check("reset out_last", ol4, 0);
    check("reset busy", busy4, 0);
    check("reset swap_cnt", sc4, 0);
    check("reset out_data known", 32'($isunknown(od4)), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 4; t++)
      run4(tbl[t].vin, tbl[t].want, tbl[t].cyc, tbl[t].swp, tbl[t].pat,
           t[0], 1'b0, $sformatf("vec%0d", t));

    // Reset on the second SORT cycle of [3,1,2,0].
    vin = pack4(3,1,2,0);
    for (int k = 0; k < 4; k++) begin
      iv4 = 1'b1;
      id4 = vin[4*k +: 4];
      @(posedge clk);
      @(negedge clk);
    end
    iv4 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midsort busy", busy4, 1);
    rst_n = 1'b0;
    #1;
    check("midsort reset in_ready", ir4, 1);
    check("midsort reset out_valid", ov4, 0);
    check("midsort reset busy", busy4, 0);
    check("midsort reset out_last", ol4, 0);
    check("midsort reset swap_cnt", sc4, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run4(pack4(1,0,3,2), pack4(0,1,2,3), 5, 2, 32'hFFFF_FFFF, 1'b0, 1'b0, "postreset");

    // One-word instance: no SORT cycles, valid right after the handshake.
    for (int t = 0; t < 3; t++) begin
      logic [3:0] d;
      d = (t == 0) ? 4'd5 : 4'($urandom);
      check($sformatf("n1 in_ready %0d", t), ir1, 1);
      iv1 = 1'b1; id1 = d; or1 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      iv1 = 1'b0;
      check($sformatf("n1 out_valid %0d", t), ov1, 1);
      check($sformatf("n1 out_data %0d", t), od1, d);
      check($sformatf("n1 out_last %0d", t), ol1, 1);
      check($sformatf("n1 swap_cnt %0d", t), sc1, 0);
      check($sformatf("n1 in_ready drain %0d", t), ir1, 0);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("n1 stall data %0d", t), od1, d);
      check($sformatf("n1 stall valid %0d", t), ov1, 1);
      or1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("n1 back to load %0d", t), ir1, 1);
      check($sformatf("n1 valid drop %0d", t), ov1, 0);
    end

    for (int r = 0; r < 25; r++) begin
      vin = 16'($urandom);
      if (r % 5 == 0) vin = {vin[3:0], vin[3:0], vin[11:8], vin[11:8]};
      model4(vin, m_sorted, m_cyc, m_swp, trace);
      run4(vin, m_sorted, m_cyc, m_swp, (r < 5) ? 32'hFFFF_FFFF : $urandom,
           1'($urandom), 1'($urandom), $sformatf("rnd%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bubble_sort_seq.md
Name: bubble_sort_seq

Overview:
- Sequential, area-lean bubble sorter. Time-multiplexes one compare-swap unit over a DATA_N-entry register buffer.
- Replaces the fully unrolled combinational sorter where N²/2 comparators or the long combinational path is unacceptable.
- Operation: accepts DATA_N words on a valid/ready input stream, sorts ascending with one compare-swap per clock and pass-level early exit, then streams the sorted words out on a valid/ready output.

Parameters:
- DATA_N, 4, number of words per sort batch; legal range ≥1.
- DATA_W, 4, width of each word in bits; data is unsigned.
- CNT_W, $clog2(DATA_N*(DATA_N-1)/2+1), width of the swap counter; derived, do not override.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_data  in  DATA_W  input word.
- in_ready  out  1  high only in LOAD.
- out_valid  out  1  sorted word valid; high only in DRAIN.
- out_data  out  DATA_W  sorted word, smallest first.
- out_last  out  1  high with the final (DATA_N-1th) output word.
- busy  out  1  high in SORT and DRAIN.
- swap_cnt  out  CNT_W  swaps performed in the current/last batch; held until the next batch's first input handshake.

Behaviour:
- Reset (async assert, sync-release assumed upstream):
  - state=LOAD; wr_idx=rd_idx=0; i=j=0; swapped=0; swap_cnt=0.
  - in_ready=1, out_valid=0, out_last=0, busy=0.
  - Buffer contents don't-care.
- LOAD:
  - On in_valid&&in_ready: buf[wr_idx]<=in_data; wr_idx++.
  - First handshake of a batch also clears swap_cnt.
  - On handshake with wr_idx==DATA_N-1: go to SORT (DATA_N==1: go directly to DRAIN); i=0, j=0, swapped=0.
- SORT: one cycle per compare; in_ready=0.
  - Each cycle compare buf[i], buf[i+1]; if buf[i+1]<buf[i] swap them (strict: equal values never swap, so the sort is stable), set swapped, swap_cnt++.
  - If i<DATA_N-2-j: i++.
  - Else (end of pass): if no swap in the pass, counting this cycle, go to DRAIN (early exit). Else if j==DATA_N-2, go to DRAIN. Else j++, i=0, swapped=0.
  - SORT duration: min DATA_N-1 cycles (already sorted), max DATA_N*(DATA_N-1)/2.
- DRAIN:
  - out_valid=1; out_data=buf[rd_idx] (registered buffer read, no extra latency); out_last=(rd_idx==DATA_N-1).
  - On out_valid&&out_ready: rd_idx++.
  - On final handshake: rd_idx=0, wr_idx=0, go to LOAD. in_ready rises the next cycle, with no same-cycle turnaround.
  - out_ready low holds out_data/out_last stable indefinitely.
- Latency: last input handshake → out_valid asserted after exactly SORT-cycle-count+1 clocks (0 SORT cycles when DATA_N==1).
- Boundaries:
  - in_valid during SORT/DRAIN is ignored (in_ready=0); no data is lost upstream.
  - swap_cnt cannot overflow; CNT_W covers the maximum.
  - Reset mid-LOAD/SORT/DRAIN discards the batch and returns to the reset state immediately (async).
- No X on outputs after reset; out_data is don't-care while out_valid=0 but must be a stable, non-X buffer value.

Decomposition:
- Package bubble_sort_pkg:
  - state enum {LOAD, SORT, DRAIN}, 2-bit;
  - function max_swaps(n)=n*(n-1)/2, used to derive CNT_W.
- Sub-module bubble_cmp_swap (combinational): inputs a, b; outputs lo, hi, swap; swap=(b<a). It is the single shared datapath element, instanced once.
- Controller FSM, index counters and buffer live in bubble_sort_seq.

Test Plan:
- N=4,W=4, load [3,1,2,0], out_ready=1 → SORT lasts 6 cycles, swap_cnt=5, outputs 0,1,2,3 with out_last on 3.
- Load [0,1,2,3] → early exit after 3 SORT cycles, swap_cnt=0, outputs 0,1,2,3.
- Load [2,2,1,1] → outputs 1,1,2,2; swap_cnt=4; equal elements never swapped (check swap flag per cycle).
- Load [3,2,1,0], then out_ready toggled 1,0,0,1,0,1,1 during DRAIN → outputs 0,1,2,3 with each word held stable while stalled; in_ready=0 throughout; in_ready=1 the cycle after the last handshake.
- Assert rst_n=0 on SORT cycle 2 of [3,1,2,0] → outputs at reset values the same cycle; a fresh batch [1,0,3,2] then yields 0,1,2,3, swap_cnt=2.
- DATA_N=1: load [5] → no SORT cycles, out_valid the next cycle with out_data=5, out_last=1, swap_cnt=0.
